// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// Supports per-entry kill (bubble conversion), synchronous flush and NOP output masking.
module pipe_stage_buf #(
  parameter int                DATA_W    = 64,
  parameter int                CTRL_W    = 32,
  parameter logic [CTRL_W-1:0] KILL_MASK = 32'h0000_000F,
  parameter logic [15:0]       NOP_INSTR = 16'h0800,
  parameter int                CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_kill,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [15:0]       in_instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [15:0]       out_instr,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  kill_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DATA_W-1:0] r_head_data;
  logic [CTRL_W-1:0] r_head_ctrl;
  logic [15:0]       r_head_instr;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [15:0]       r_skid_instr;
  logic              r_out_valid;
  logic              r_in_ready;
  logic [CNT_W-1:0]  r_kill_cnt;

  logic              w_acc;
  logic              w_pop;
  logic [CTRL_W-1:0] w_in_ctrl;
  logic              w_load_head_in;
  logic              w_load_head_skid;
  logic              w_load_skid;

  assign w_acc     = in_valid & r_in_ready;
  assign w_pop     = r_out_valid & out_ready;
  assign w_in_ctrl = in_kill ? (in_ctrl & ~KILL_MASK) : in_ctrl;

  always_comb begin
    w_state_next     = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_acc) begin
          w_state_next   = S_ONE;
          w_load_head_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_acc && w_pop) begin
          w_load_head_in = 1'b1;
        end else if (w_acc) begin
          w_state_next = S_FULL;
          w_load_skid  = 1'b1;
        end else if (w_pop) begin
          w_state_next = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_pop) begin
          w_state_next     = S_ONE;
          w_load_head_skid = 1'b1;
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
    // Flush wins over everything; a pop in the same cycle has already been taken downstream.
    if (flush) begin
      w_state_next     = S_EMPTY;
      w_load_head_in   = 1'b0;
      w_load_head_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= (w_state_next != S_EMPTY);
      r_in_ready  <= (w_state_next != S_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head_data  <= '0;
      r_head_ctrl  <= '0;
      r_head_instr <= NOP_INSTR;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
      r_skid_instr <= NOP_INSTR;
    end else begin
      if (w_load_head_in) begin
        r_head_data  <= in_data;
        r_head_ctrl  <= w_in_ctrl;
        r_head_instr <= in_instr;
      end else if (w_load_head_skid) begin
        r_head_data  <= r_skid_data;
        r_head_ctrl  <= r_skid_ctrl;
        r_head_instr <= r_skid_instr;
      end
      if (w_load_skid) begin
        r_skid_data  <= in_data;
        r_skid_ctrl  <= w_in_ctrl;
        r_skid_instr <= in_instr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_kill_cnt <= '0;
    end else if (w_acc && in_kill && !flush && (r_kill_cnt != {CNT_W{1'b1}})) begin
      r_kill_cnt <= r_kill_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_head_data;
  assign out_ctrl  = r_out_valid ? r_head_ctrl : '0;
  assign out_instr = r_out_valid ? r_head_instr : NOP_INSTR;
  assign occupancy = r_state;
  assign kill_cnt  = r_kill_cnt;

endmodule
